// File: rtl/gsim_mem_sched_if.sv
// gsim_mem_sched_if: memory request/response bus and line-delivery handshake
// between the memory scheduler (master), the matrix memory and the
// Gauss-Seidel compute core (both seen together as the slave side).
interface gsim_mem_sched_if;
   logic         o_mem_rreq;
   logic [9:0]   o_mem_addr;
   logic         i_mem_rrdy;
   logic [255:0] i_mem_dout;
   logic         i_mem_dout_vld;
   logic         o_line_vld;
   logic [255:0] o_line_data;
   logic [4:0]   o_line_col;
   logic [3:0]   o_line_iter;
   logic [4:0]   o_line_mat;
   logic         i_line_rdy;

   modport master (
      output o_mem_rreq, o_mem_addr, o_line_vld, o_line_data,
             o_line_col, o_line_iter, o_line_mat,
      input  i_mem_rrdy, i_mem_dout, i_mem_dout_vld, i_line_rdy
   );

   modport slave (
      input  o_mem_rreq, o_mem_addr, o_line_vld, o_line_data,
             o_line_col, o_line_iter, o_line_mat,
      output i_mem_rrdy, i_mem_dout, i_mem_dout_vld, i_line_rdy
   );
endinterface

// File: rtl/gsim_mem_sched.sv
// gsim_mem_sched: read-request scheduler and in-order response buffer for the
// Gauss-Seidel core. Walks the per-matrix line sequence (b line, then
// N_ITER sweeps of columns 0..15), paces it with credits so the response
// FIFO can never overflow, and tags every buffered line with mat/iter/col.
// Optional: define GSIM_SCHED_PERF_EN to build the request stall counter.
module gsim_mem_sched #(
   parameter int FIFO_DEPTH = 4,
   parameter int N_ITER     = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [4:0]  i_matrix_num,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [15:0] o_stall_cnt,
   gsim_mem_sched_if.master bus
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   // col 16 marks the b line of a matrix
   typedef struct packed {
      logic [4:0] mat;
      logic [3:0] iter;
      logic [4:0] col;
   } tag_t;

   localparam tag_t TAG_FIRST = '{mat: 5'd0, iter: 4'd0, col: 5'd16};

   state_t          state_q, state_d;
   logic [4:0]      num_q, num_d;
   tag_t            req_q, req_d;
   tag_t            rsp_q, rsp_d;
   logic            rreq_q, rreq_d;
   logic [9:0]      addr_q, addr_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            err_q, err_d;
   logic [CW:0]     credit_used;

   logic [255:0]    data_mem [FIFO_DEPTH];
   tag_t            tag_mem  [FIFO_DEPTH];

   logic            accept, rsp_ok, pop, last_req, line_vld;
   tag_t            head_tag;

   // Next position in the b-line / column / iteration / matrix walk.
   function automatic tag_t next_tag(input tag_t t);
      tag_t n;
      n = t;
      if (t.col == 5'd16) begin
         n.col = 5'd0;
      end else if (t.col == 5'd15) begin
         n.col = 5'd0;
         if (t.iter == 4'(N_ITER - 1)) begin
            n.iter = 4'd0;
            n.mat  = t.mat + 5'd1;
            n.col  = 5'd16;
         end else begin
            n.iter = t.iter + 4'd1;
         end
      end else begin
         n.col = t.col + 5'd1;
      end
      return n;
   endfunction

   assign accept   = rreq_q && bus.i_mem_rrdy;
   assign rsp_ok   = bus.i_mem_dout_vld && (outst_q != '0);
   assign line_vld = (cnt_q != '0);
   assign pop      = line_vld && bus.i_line_rdy;
   assign last_req = (req_q.mat == num_q - 5'd1) && (req_q.iter == 4'(N_ITER - 1))
                     && (req_q.col == 5'd15);

   // Next-state logic for the FSM, request walk, credits and FIFO pointers.
   // NOTE: every _d gets its _q as a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      req_d    = req_q;
      rsp_d    = rsp_q;
      outst_d  = outst_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      err_d    = err_q | (bus.i_mem_dout_vld && (outst_q == '0));

      if (accept) req_d = next_tag(req_q);
      if (rsp_ok) begin
         rsp_d    = next_tag(rsp_q);
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      case ({accept, rsp_ok})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase
      case ({rsp_ok, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      case (state_q)
         S_IDLE: if (i_start) begin
            num_d   = i_matrix_num;
            req_d   = TAG_FIRST;
            rsp_d   = TAG_FIRST;
            state_d = (i_matrix_num == 5'd0) ? S_DONE : S_RUN;
         end
         S_RUN:   if (accept && last_req) state_d = S_DRAIN;
         S_DRAIN: if ((outst_q == '0) && (cnt_q == '0)) state_d = S_DONE;
         S_DONE:  if (!i_start) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Credits are judged on next-cycle counts so an issued request always has a FIFO slot.
      credit_used = {1'b0, outst_d} + {1'b0, cnt_d};
      rreq_d      = (state_d == S_RUN) && (credit_used < (CW + 1)'(FIFO_DEPTH));
      addr_d      = 10'(req_d.mat) * 10'd17 + 10'(req_d.col);
   end

`ifdef GSIM_SCHED_PERF_EN
   logic [15:0] stall_q, stall_d;

   // Count RUN cycles that do not retire a request (rrdy low or no credit).
   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_IDLE) && (state_d == S_RUN)) stall_d = '0;
      else if ((state_q == S_RUN) && !accept && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
   end

   assign o_stall_cnt = stall_q;
`else
   assign o_stall_cnt = '0;
`endif

   // Control registers: FSM state, request/response walks, credits, pointers.
   // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         num_q    <= '0;
         req_q    <= '0;
         rsp_q    <= '0;
         rreq_q   <= 1'b0;
         addr_q   <= '0;
         outst_q  <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
`ifdef GSIM_SCHED_PERF_EN
         stall_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         req_q    <= req_d;
         rsp_q    <= rsp_d;
         rreq_q   <= rreq_d;
         addr_q   <= addr_d;
         outst_q  <= outst_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
`ifdef GSIM_SCHED_PERF_EN
         stall_q  <= stall_d;
`endif
      end
   end

   // Response FIFO storage: write the returned line and its tags at the tail.
   // NOTE: storage is not reset; an empty count masks stale entries from the outputs.
   always_ff @(posedge i_clk) begin
      if (rsp_ok) begin
         data_mem[wr_ptr_q] <= bus.i_mem_dout;
         tag_mem[wr_ptr_q]  <= rsp_q;
      end
   end

   assign head_tag        = tag_mem[rd_ptr_q];
   assign bus.o_mem_rreq  = rreq_q;
   assign bus.o_mem_addr  = addr_q;
   assign bus.o_line_vld  = line_vld;
   assign bus.o_line_data = line_vld ? data_mem[rd_ptr_q] : '0;
   assign bus.o_line_col  = line_vld ? head_tag.col  : '0;
   assign bus.o_line_iter = line_vld ? head_tag.iter : '0;
   assign bus.o_line_mat  = line_vld ? head_tag.mat  : '0;
   assign o_busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign o_done          = (state_q == S_DONE);
   assign o_err           = err_q;

endmodule

// File: tb/tb_gsim_mem_sched.sv
// tb_gsim_mem_sched: directed/randomised bench for gsim_mem_sched. The
// expected request stream and line tags come from nested loops over the
// matrix/iteration/column walk; a queue-based memory model returns random
// lines in request order and a queue of expected lines checks the core side.
module tb_gsim_mem_sched;
   localparam int FIFO_DEPTH = 4;
   localparam int N_ITER     = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  num;
   logic        busy, done, err;
   logic [15:0] stall_cnt;

   gsim_mem_sched_if bus ();

   gsim_mem_sched #(.FIFO_DEPTH(FIFO_DEPTH), .N_ITER(N_ITER)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_matrix_num (num),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err),
      .o_stall_cnt  (stall_cnt),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int mat; int iter; int col; } req_t;
   typedef struct { logic [255:0] data; int mat; int iter; int col; } line_t;
   typedef struct { logic [255:0] data; longint due; } rsp_t;

   req_t  ref_q[$];
   line_t exp_q[$];
   rsp_t  pend_q[$];

   int     checks = 0;
   int     failures = 0;
   longint cyc = 0;
   longint last_due = 0;
   int     acc_cnt, pop_cnt, stall_model;
   int     last_addr, last_mat, first_addr;
   int     rrdy_pct, rdy_pct, lat_min, lat_max;
   bit     in_run, prev_stalled, spurious, obs_done;
   logic [9:0] prev_addr;

   task automatic chk(input logic [255:0] obs, input logic [255:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Expected request stream: per matrix the b line, then every column of every sweep.
   task automatic build_ref(input int n);
      ref_q.delete();
      for (int m = 0; m < n; m++) begin
         ref_q.push_back('{addr: 17*m + 16, mat: m, iter: 0, col: 16});
         for (int it = 0; it < N_ITER; it++)
            for (int c = 0; c < 16; c++)
               ref_q.push_back('{addr: 17*m + c, mat: m, iter: it, col: c});
      end
   endtask

   // One clock cycle: observe outputs at the falling edge, then drive inputs for the next rising edge.
   task automatic step();
      logic       o_rreq, o_vld, rrdy, lrdy;
      logic [9:0] o_addr;
      line_t      e;
      rsp_t       r;
      @(negedge clk);
      cyc++;
      o_rreq   = bus.o_mem_rreq;
      o_addr   = bus.o_mem_addr;
      o_vld    = bus.o_line_vld;
      obs_done = done;

      if (prev_stalled) begin
         chk(o_rreq, 1'b1, "rreq_hold");
         chk(o_addr, prev_addr, "addr_hold");
      end

      rrdy = ($urandom_range(99) < rrdy_pct);
      lrdy = ($urandom_range(99) < rdy_pct);
      bus.i_mem_rrdy = rrdy;
      bus.i_line_rdy = lrdy;

      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         bus.i_mem_dout_vld = 1'b1;
         bus.i_mem_dout     = pend_q[0].data;
         void'(pend_q.pop_front());
      end else if (spurious) begin
         bus.i_mem_dout_vld = 1'b1;
         bus.i_mem_dout     = rand256();
      end else begin
         bus.i_mem_dout_vld = 1'b0;
         bus.i_mem_dout     = '0;
      end

      if (in_run && !(o_rreq && rrdy) && stall_model < 65535) stall_model++;

      if (o_rreq && rrdy) begin
         if (acc_cnt < ref_q.size()) begin
            chk(o_addr, ref_q[acc_cnt].addr, "req_addr");
            r.data = rand256();
            r.due  = cyc + $urandom_range(lat_max, lat_min);
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            pend_q.push_back(r);
            exp_q.push_back('{data: r.data, mat: ref_q[acc_cnt].mat,
                              iter: ref_q[acc_cnt].iter, col: ref_q[acc_cnt].col});
            if (acc_cnt == 0) first_addr = o_addr;
            last_addr = o_addr;
            acc_cnt++;
            if (acc_cnt == ref_q.size()) in_run = 1'b0;
         end else begin
            chk(o_rreq && rrdy, 1'b0, "unexpected_req");
         end
      end

      if (o_vld && lrdy) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(bus.o_line_data, e.data, "line_data");
            chk(bus.o_line_mat,  e.mat,  "line_mat");
            chk(bus.o_line_iter, e.iter, "line_iter");
            chk(bus.o_line_col,  e.col,  "line_col");
            last_mat = bus.o_line_mat;
            pop_cnt++;
         end else begin
            chk(o_vld, 1'b0, "unexpected_line");
         end
      end

      if (o_rreq && rrdy) chk(acc_cnt - pop_cnt <= FIFO_DEPTH, 1'b1, "credit_limit");

      prev_stalled = o_rreq && !rrdy;
      prev_addr    = o_addr;
   endtask

   task automatic start_run(input int n);
      num   = 5'(n);
      start = 1'b1;
      build_ref(n);
      acc_cnt  = 0;
      pop_cnt  = 0;
      last_due = cyc;
      if (n != 0) stall_model = 0;
      step();
      if (n != 0) in_run = 1'b1;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !obs_done; i++) step();
      chk(obs_done, 1'b1, "done_timeout");
   endtask

   task automatic finish_run();
      start = 1'b0;
      step();
      step();
      chk(done, 1'b0, "idle_done");
      chk(busy, 1'b0, "idle_busy");
   endtask

   task automatic check_stall();
`ifdef GSIM_SCHED_PERF_EN
      chk(stall_cnt, stall_model, "stall_cnt");
`else
      chk(stall_cnt, 16'd0, "stall_cnt_off");
`endif
   endtask

   task automatic check_all_zero(input string tag);
      chk(busy, 1'b0, {tag, "_busy"});
      chk(done, 1'b0, {tag, "_done"});
      chk(err,  1'b0, {tag, "_err"});
      chk(stall_cnt, 16'd0, {tag, "_stall"});
      chk(bus.o_mem_rreq, 1'b0, {tag, "_rreq"});
      chk(bus.o_mem_addr, 10'd0, {tag, "_addr"});
      chk(bus.o_line_vld, 1'b0, {tag, "_vld"});
      chk(bus.o_line_data, 256'd0, {tag, "_data"});
      chk(bus.o_line_col, 5'd0, {tag, "_col"});
      chk(bus.o_line_iter, 4'd0, {tag, "_iter"});
      chk(bus.o_line_mat, 5'd0, {tag, "_mat"});
   endtask

   // Reset asserted between clock edges; outputs must clear without waiting for a clock.
   task automatic mid_reset();
      #2 rst = 1'b1;
      #1 check_all_zero("reset");
      bus.i_mem_dout_vld = 1'b0;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_run = 1'b0;
      prev_stalled = 1'b0;
      exp_q.delete();
      ref_q.delete();
      acc_cnt = 0;
      pop_cnt = 0;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      num = '0;
      bus.i_mem_rrdy = 1'b0;
      bus.i_mem_dout = '0;
      bus.i_mem_dout_vld = 1'b0;
      bus.i_line_rdy = 1'b0;
      in_run = 1'b0;
      prev_stalled = 1'b0;
      spurious = 1'b0;
      obs_done = 1'b0;
      acc_cnt = 0;
      pop_cnt = 0;
      stall_model = 0;
      #1 check_all_zero("por");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Spurious response while idle sets the sticky error.
      rrdy_pct = 100; rdy_pct = 100; lat_min = 2; lat_max = 2;
      spurious = 1'b1;
      step();
      spurious = 1'b0;
      step();
      chk(err, 1'b1, "spurious_err");
      step();
      chk(err, 1'b1, "err_sticky");
      mid_reset();

      // Basic single-matrix run, latency 2, no backpressure.
      start_run(1);
      chk(bus.o_mem_rreq, 1'b1, "first_rreq");
      chk(bus.o_mem_addr, 10'd16, "first_addr");
      chk(busy, 1'b1, "run_busy");
      wait_done(2000);
      chk(pop_cnt, 257, "basic_pops_at_done");
      chk(acc_cnt, 257, "basic_accepts");
      check_stall();
      finish_run();

      // Three matrices with random memory stalls, random core backpressure, random latency.
      rrdy_pct = 60; rdy_pct = 70; lat_min = 1; lat_max = 4;
      start_run(3);
      wait_done(20000);
      chk(acc_cnt, 771, "multi_accepts");
      chk(pop_cnt, 771, "multi_pops");
      chk(last_addr, 49, "multi_last_addr");
      chk(last_mat, 2, "multi_last_mat");
      check_stall();
      finish_run();

      // Core backpressure: credits stop requests at FIFO_DEPTH, one pop frees one request.
      rrdy_pct = 100; rdy_pct = 0; lat_min = 2; lat_max = 2;
      start_run(1);
      repeat (20) step();
      chk(acc_cnt, FIFO_DEPTH, "bp_accepts");
      chk(bus.o_mem_rreq, 1'b0, "bp_rreq_low");
      chk(bus.o_line_vld, 1'b1, "bp_line_vld");
      rdy_pct = 100;
      step();
      rdy_pct = 0;
      repeat (10) step();
      chk(acc_cnt, FIFO_DEPTH + 1, "bp_one_more");
      chk(pop_cnt, 1, "bp_one_pop");
      rdy_pct = 100;
      wait_done(3000);
      chk(pop_cnt, 257, "bp_pops");
      check_stall();
      finish_run();

      // Zero matrices: straight to done, no requests.
      start_run(0);
      chk(done, 1'b1, "zero_done");
      chk(busy, 1'b0, "zero_busy");
      chk(bus.o_mem_rreq, 1'b0, "zero_rreq");
      step();
      chk(bus.o_mem_rreq, 1'b0, "zero_rreq_hold");
      finish_run();

      // Reset in the middle of a run; responses still in flight arrive afterwards.
      rrdy_pct = 100; rdy_pct = 100; lat_min = 4; lat_max = 4;
      start_run(2);
      repeat (40) step();
      mid_reset();
      repeat (8) step();
      chk(err, 1'b1, "late_rsp_err");
      chk(busy, 1'b0, "late_rsp_idle");
      mid_reset();

      // Fresh run after reset, with random stalls on both sides.
      rrdy_pct = 50; rdy_pct = 80; lat_min = 1; lat_max = 3;
      start_run(1);
      wait_done(5000);
      chk(first_addr, 16, "post_reset_first_addr");
      chk(pop_cnt, 257, "post_reset_pops");
      chk(err, 1'b0, "post_reset_err");
      check_stall();
      finish_run();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
